// File: rtl/arch_pkg.sv
// Shared definitions for the AND16 request sequencer slice.
//   DATA_W      : datapath width of the shared AND unit
//   seq_state_t : sequencer FSM encoding
package arch_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } seq_state_t;

endpackage

// File: rtl/MyAnd16.sv
// Purely combinational 16-bit bitwise AND datapath.
//   A, B : operands
//   OUT  : A & B
module MyAnd16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] OUT
);

  assign OUT = A & B;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : index of the most recent winner; scanning starts at last+1
//   gnt    : one-hot grant (all zero when nothing requests)
//   gnt_id : binary index of the granted requester
//   any    : at least one request present
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  int unsigned idx;

  // Scan last+1 .. last+N (mod N); the first hit wins, so last itself
  // comes up at the very end of the rotation.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/and16_rr_sequencer.sv
// Shares one MyAnd16 unit between N_REQ requesters with round-robin
// arbitration and a single ID-tagged response channel.
//   CLK, RESET : clock, synchronous active-high reset
//   REQ_VALID  : per-requester request valid
//   REQ_A/B    : packed operands, requester i at [16*i +: 16]
//   REQ_READY  : one-hot grant, handshake on VALID & READY
//   RSP_VALID  : result available
//   RSP_ID     : requester owning the result
//   RSP_DATA   : A & B of that request
//   RSP_READY  : consumer accepts result
//   BUSY       : FSM not in IDLE
module and16_rr_sequencer
  import arch_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        REQ_VALID,
  input  logic [N_REQ*DATA_W-1:0] REQ_A,
  input  logic [N_REQ*DATA_W-1:0] REQ_B,
  output logic [N_REQ-1:0]        REQ_READY,
  output logic                    RSP_VALID,
  output logic [ID_W-1:0]         RSP_ID,
  output logic [DATA_W-1:0]       RSP_DATA,
  input  logic                    RSP_READY,
  output logic                    BUSY
);

  seq_state_t        state;
  logic [ID_W-1:0]   last;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ID_W-1:0]   op_id;
  logic [DATA_W-1:0] and_out;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              any;
  logic              arb_slot;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (REQ_VALID),
    .last   (last),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  MyAnd16 a16 (
    .A   (op_a),
    .B   (op_b),
    .OUT (and_out)
  );

  // Arbitration happens in IDLE, and in RESP on the same cycle the current
  // result is consumed (back-to-back path).
  assign arb_slot  = (state == S_IDLE) || ((state == S_RESP) && RSP_READY);
  assign REQ_READY = (!RESET && arb_slot) ? gnt : '0;
  assign BUSY      = (state != S_IDLE);

  always_comb begin
    sel_a = REQ_A[DATA_W*32'(gnt_id) +: DATA_W];
    sel_b = REQ_B[DATA_W*32'(gnt_id) +: DATA_W];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      last      <= ID_W'(N_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_DATA  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_id <= gnt_id;
            last  <= gnt_id;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          RSP_DATA  <= and_out;
          RSP_ID    <= op_id;
          RSP_VALID <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            if (any) begin
              op_a  <= sel_a;
              op_b  <= sel_b;
              op_id <= gnt_id;
              last  <= gnt_id;
              state <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
